round_robin_arbiter: RTL and testbench



---
 rtl/round_robin_arbiter_pkg.sv | 16 +
 rtl/first_one.sv | 32 +++
 rtl/round_robin_mask.sv | 18 +
 rtl/round_robin_arbiter.sv | 125 ++++++++++++
 tb/tb_round_robin_arbiter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package round_robin_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Hold counter width: enough for 0..HOLD_LIMIT, never narrower than one bit.
    function automatic int hold_width(input int hold_limit);
        int w;
        w = $clog2(hold_limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/first_one.sv
// Isolates the lowest set bit of a vector; two equivalent implementations.
module first_one #(
    parameter int    WIDTH   = 4,
    parameter string VARIANT = "fast"
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [WIDTH-1:0] out_vec
);

    generate
        if (VARIANT == "small") begin : g_small
            // Priority scan from the top so the lowest set index wins last.
            always_comb begin
                out_vec = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (in_vec[i]) begin
                        out_vec = '0;
                        out_vec[i] = 1'b1;
                    end else begin
                        out_vec = out_vec;
                    end
                end
            end
        end else begin : g_fast
            // Two's-complement trick: x & -x keeps only the lowest set bit.
            always_comb begin
                out_vec = in_vec & (~in_vec + WIDTH'(1));
            end
        end
    endgenerate

endmodule

// File: rtl/round_robin_mask.sv
// Next priority mask: every index strictly above the one-hot winner.
module round_robin_mask #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] winner,
    output logic [WIDTH-1:0] mask
);

    // Prefix-OR of winner shifted left by one.
    always_comb begin
        mask    = '0;
        mask[0] = 1'b0;
        for (int k = 1; k < WIDTH; k++) begin
            mask[k] = mask[k-1] | winner[k-1];
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter with grant lock and optional hold limit.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int    WIDTH      = 4,
    parameter int    HOLD_LIMIT = 0,
    parameter string VARIANT    = "fast"
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] requests,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic             tenure_start
);

    localparam int HOLD_WIDTH = hold_width(HOLD_LIMIT);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
        HOLD_WIDTH'((HOLD_LIMIT == 0) ? 0 : HOLD_LIMIT - 1);

    arb_state_e            state_q, state_d;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [WIDTH-1:0]      grant_q, grant_d;
    logic [HOLD_WIDTH-1:0] hold_count_q, hold_count_d;
    logic                  grant_valid_q, grant_valid_d;
    logic                  tenure_start_q, tenure_start_d;

    logic [WIDTH-1:0]      masked_s;
    logic [WIDTH-1:0]      masked_win_s;
    logic [WIDTH-1:0]      raw_win_s;
    logic [WIDTH-1:0]      winner_s;
    logic [WIDTH-1:0]      next_mask_s;
    logic                  owner_req_s;
    logic                  limit_hit_s;

    first_one #(.WIDTH(WIDTH), .VARIANT(VARIANT)) u_first_masked (
        .in_vec  (masked_s),
        .out_vec (masked_win_s)
    );

    first_one #(.WIDTH(WIDTH), .VARIANT(VARIANT)) u_first_raw (
        .in_vec  (requests),
        .out_vec (raw_win_s)
    );

    round_robin_mask #(.WIDTH(WIDTH)) u_mask (
        .winner (winner_s),
        .mask   (next_mask_s)
    );

    // Winner selection; an empty masked set wraps to the raw requests.
    always_comb begin
        masked_s    = requests & mask_q;
        winner_s    = (|masked_s) ? masked_win_s : raw_win_s;
        owner_req_s = |(requests & grant_q);
        limit_hit_s = (HOLD_LIMIT != 0) && (hold_count_q == HOLD_LAST);
    end

    // Next-state logic; owner drop and forced release share one arbitration.
    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        grant_d        = grant_q;
        hold_count_d   = hold_count_q;
        tenure_start_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|requests) begin
                    state_d        = ARB_OWNED;
                    grant_d        = winner_s;
                    mask_d         = next_mask_s;
                    hold_count_d   = '0;
                    tenure_start_d = 1'b1;
                end else begin
                    grant_d      = '0;
                    hold_count_d = '0;
                end
            end
            ARB_OWNED: begin
                if (owner_req_s && !limit_hit_s) begin
                    hold_count_d = hold_count_q + HOLD_WIDTH'(1);
                end else if (|requests) begin
                    grant_d        = winner_s;
                    mask_d         = next_mask_s;
                    hold_count_d   = '0;
                    tenure_start_d = 1'b1;
                end else begin
                    state_d      = ARB_IDLE;
                    grant_d      = '0;
                    hold_count_d = '0;
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                grant_d      = '0;
                hold_count_d = '0;
            end
        endcase
        grant_valid_d = |grant_d;
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ARB_IDLE;
            mask_q         <= '1;
            grant_q        <= '0;
            hold_count_q   <= '0;
            grant_valid_q  <= 1'b0;
            tenure_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            grant_q        <= grant_d;
            hold_count_q   <= hold_count_d;
            grant_valid_q  <= grant_valid_d;
            tenure_start_q <= tenure_start_d;
        end
    end

    assign grant        = grant_q;
    assign grant_valid  = grant_valid_q;
    assign tenure_start = tenure_start_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench: unlimited-hold arbiter plus a HOLD_LIMIT=3 instance.
module tb_round_robin_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req0, req3;
    logic [3:0] grant0, grant3;
    logic       gv0, gv3, ts0, ts3;

    int checks   = 0;
    int failures = 0;

    round_robin_arbiter #(.WIDTH(4), .HOLD_LIMIT(0), .VARIANT("fast")) dut0 (
        .clock        (clock),
        .reset        (reset),
        .requests     (req0),
        .grant        (grant0),
        .grant_valid  (gv0),
        .tenure_start (ts0)
    );

    round_robin_arbiter #(.WIDTH(4), .HOLD_LIMIT(3), .VARIANT("small")) dut3 (
        .clock        (clock),
        .reset        (reset),
        .requests     (req3),
        .grant        (grant3),
        .grant_valid  (gv3),
        .tenure_start (ts3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect0(input string tag, input logic [3:0] g, input logic t);
        check({tag, "_grant"}, {4'b0000, grant0}, {4'b0000, g});
        check({tag, "_valid"}, {7'b0000000, gv0}, {7'b0000000, |g});
        check({tag, "_ts"}, {7'b0000000, ts0}, {7'b0000000, t});
    endtask

    task automatic expect3(input string tag, input logic [3:0] g, input logic t);
        check({tag, "_grant"}, {4'b0000, grant3}, {4'b0000, g});
        check({tag, "_ts"}, {7'b0000000, ts3}, {7'b0000000, t});
    endtask

    logic [3:0] rr_req  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] rr_exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] hl_exp  [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic       hl_ts   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int         wait_ten [4];
        int         worst;
        logic [3:0] applied;

        reset = 1'b0;
        req0  = 4'b0000;
        req3  = 4'b0000;
        #1 reset = 1'b1;
        #1;
        expect0("reset", 4'b0000, 1'b0);
        expect3("reset3", 4'b0000, 1'b0);
        #1 reset = 1'b0;

        // First grant, then lock while bit1 stays high.
        req0 = 4'b1010;
        step();
        expect0("first", 4'b0010, 1'b1);
        step();
        expect0("hold", 4'b0010, 1'b0);

        // Zero-bubble handover and wrap-around.
        req0 = 4'b1000;
        step();
        expect0("handover", 4'b1000, 1'b1);
        req0 = 4'b0001;
        step();
        expect0("wrap", 4'b0001, 1'b1);

        // Rotation with each owner releasing after one cycle.
        for (int i = 0; i < 4; i++) begin
            req0 = rr_req[i];
            step();
            expect0($sformatf("rotate%0d", i), rr_exp[i], 1'b1);
        end

        // Idle: nothing granted, no tenure pulse.
        req0 = 4'b0000;
        step();
        expect0("idle_a", 4'b0000, 1'b0);
        step();
        expect0("idle_b", 4'b0000, 1'b0);

        // Asynchronous reset mid-tenure, then mask is all ones again.
        req0 = 4'b0100;
        step();
        expect0("pre_reset", 4'b0100, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_grant", {4'b0000, grant0}, 8'h00);
        check("async_valid", {7'b0000000, gv0}, 8'h00);
        #1 reset = 1'b0;
        req0 = 4'b1100;
        step();
        expect0("post_reset", 4'b0100, 1'b1);
        req0 = 4'b0000;
        step();

        // Hold limit 3 with two requesters.
        req3 = 4'b0011;
        for (int i = 0; i < 7; i++) begin
            step();
            expect3($sformatf("limit%0d", i), hl_exp[i], hl_ts[i]);
        end
        // Sole requester is re-granted every three cycles.
        req3 = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            expect3($sformatf("solo%0d", i), 4'b0001, (i == 2 || i == 5) ? 1'b1 : 1'b0);
        end
        req3 = 4'b0000;

        // Random soak: one-hot, grant within requests, starvation bound.
        for (int i = 0; i < 4; i++) wait_ten[i] = 0;
        worst = 0;
        for (int n = 0; n < 400; n++) begin
            applied = 4'($urandom_range(0, 15));
            if (n % 8 < 5) applied = applied | 4'b1000;
            req0 = applied;
            step();
            check("soak_onehot", {7'b0000000, (grant0 & (grant0 - 4'b0001)) != 4'b0000}, 8'h00);
            check("soak_subset", {4'b0000, grant0 & ~applied}, 8'h00);
            for (int i = 0; i < 4; i++) begin
                if (!applied[i] || grant0[i]) wait_ten[i] = 0;
                else if (ts0) wait_ten[i] = wait_ten[i] + 1;
                else wait_ten[i] = wait_ten[i];
                if (wait_ten[i] > worst) worst = wait_ten[i];
            end
        end
        check("starve_bound", {7'b0000000, worst > 3}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
